datamem_mp: RTL and testbench
=============================

DATAMEM_MP -- requirements
Module: datamem_mp

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 6, address width; depth is fixed at 2**ADDR_W words.
REQ-003 The module SHALL have parameter INIT_CNT, default 4, number of low addresses preloaded with address+1 on initialisation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 clear  input  1  request to re-run the initialisation sweep.
REQ-007 write_en  input  1  write strobe.
REQ-008 write_adr  input  ADDR_W  write address.
REQ-009 write_data  input  DATA_W  write data.
REQ-010 read  input  1  read request; both read ports sampled together.
REQ-011 read_adr1, read_adr2  input  ADDR_W each  read addresses.
REQ-012 read_data1, read_data2  output  DATA_W each  registered read data.
REQ-013 read_valid  output  1  read data valid strobe.
REQ-014 busy  output  1  high while the initialisation sweep runs.

Function
REQ-015 The block SHALL implement a two-state FSM: INIT (sweep) and READY.
REQ-016 In INIT, a ADDR_W-bit counter SHALL write one location per cycle, value counter+1 if counter < INIT_CNT else 0, incrementing from 0.
REQ-017 INIT SHALL transition to READY on the cycle the counter writes address 2**ADDR_W-1; the sweep SHALL take exactly 2**ADDR_W cycles.
REQ-018 busy SHALL be 1 in INIT and 0 in READY.
REQ-019 In INIT, write_en and read SHALL be ignored: no memory write from the port, read_valid stays 0.
REQ-020 In READY, write_en=1 SHALL store write_data at write_adr on the rising edge.
REQ-021 In READY, read=1 sampled at edge N SHALL produce read_data1/2 = mem[read_adr1]/mem[read_adr2] and read_valid=1 after edge N (latency 1).
REQ-022 read_valid SHALL be 1 for exactly one cycle per sampled read; back-to-back reads SHALL give valid every cycle.
REQ-023 When read_valid is 0, read_data1 and read_data2 SHALL be driven to 0.
REQ-024 read_adr1 equal to read_adr2 SHALL return identical data on both ports.
REQ-025 clear=1 in READY SHALL enter INIT with counter=0 on the next edge; a write or read in that same cycle SHALL be dropped.
REQ-026 clear=1 during INIT SHALL restart the sweep from counter=0.
REQ-027 Same-address write and read in one READY cycle SHALL follow the Configuration section.

Reset
REQ-028 rst=1 SHALL asynchronously force state INIT, counter 0, read_valid 0, read_data1/2 0, busy 1.
REQ-029 Memory contents SHALL not be reset directly; they SHALL be defined only by the sweep after rst deasserts.
REQ-030 rst asserted mid-sweep or mid-read SHALL abort the operation and restart the sweep from address 0 after deassertion.

Configuration
REQ-031 Macro DATAMEM_MP_BYPASS_EN defined: a read of an address written in the same cycle SHALL return the new write_data (write-first forwarding, per port).
REQ-032 Macro DATAMEM_MP_BYPASS_EN undefined: such a read SHALL return the old contents (read-first); the write still completes.

Verification
REQ-033 Release rst, hold idle -> busy=1 for 64 cycles then 0; read adr 0..4 -> 1,2,3,4,0.
REQ-034 READY, write 0xA5 to adr 10, next cycle read adr1=10, adr2=3 -> one cycle later read_data1=0xA5, read_data2=4, read_valid=1 one cycle.
REQ-035 Same cycle write 0x5A to adr 7 and read adr1=7 -> read_data1=0x5A with DATAMEM_MP_BYPASS_EN, 0x00 without.
REQ-036 Write 0xFF to adr 63, pulse clear with concurrent write 0x11 to adr 5 -> busy 64 cycles, afterwards adr 63 reads 0, adr 5 reads 0.
REQ-037 Assert rst at sweep cycle 20 for 2 cycles -> busy stays 1, full 64-cycle sweep restarts after deassertion, reads/writes during sweep ignored (read_valid 0).
REQ-038 Parameter run DATA_W=16, ADDR_W=4, INIT_CNT=2 -> sweep 16 cycles; adr 0,1,2 read 1,2,0; write 0xBEEF to adr 15 reads back 0xBEEF.

Source files
------------

// File: rtl/datamem_mp.sv
// datamem_mp: 1-write/2-read data memory with self-initialising sweep; DATAMEM_MP_BYPASS_EN enables write-first read forwarding
module datamem_mp #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int INIT_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              read,
    input  logic [ADDR_W-1:0] read_adr1,
    input  logic [ADDR_W-1:0] read_adr2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              read_valid,
    output logic              busy
);
    typedef enum logic {S_INIT, S_READY} state_t;
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic              w_we, w_rd, r_valid;
    logic [ADDR_W-1:0] w_wa;
    logic [DATA_W-1:0] w_wd, w_init_val, w_rd1, w_rd2, r_rd1, r_rd2;

    assign w_init_val = (int'(r_cnt) < INIT_CNT) ? DATA_W'(r_cnt) + DATA_W'(1) : '0;
    assign w_we       = (r_state == S_INIT) ? 1'b1 : (write_en && !clear);
    assign w_wa       = (r_state == S_INIT) ? r_cnt : write_adr;
    assign w_wd       = (r_state == S_INIT) ? w_init_val : write_data;
    assign w_rd       = (r_state == S_READY) && read && !clear;
`ifdef DATAMEM_MP_BYPASS_EN
    assign w_rd1      = (w_we && w_wa == read_adr1) ? w_wd : r_mem[read_adr1];
    assign w_rd2      = (w_we && w_wa == read_adr2) ? w_wd : r_mem[read_adr2];
`else
    assign w_rd1      = r_mem[read_adr1];
    assign w_rd2      = r_mem[read_adr2];
`endif
    assign read_data1 = r_rd1;
    assign read_data2 = r_rd2;
    assign read_valid = r_valid;
    assign busy       = (r_state == S_INIT);

    // state and sweep counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // sweep advances one word per cycle; clear restarts it from either state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == S_INIT) begin
            w_cnt_nxt   = clear ? '0 : r_cnt + ADDR_W'(1);
            w_state_nxt = (!clear && r_cnt == '1) ? S_READY : S_INIT;
        end else if (clear) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_INIT;
        end
    end

    // storage array, deliberately without reset: contents come from the sweep
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_wa] <= w_wd;
    end

    // registered read ports, zeroed whenever no read is being returned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
        end else begin
            r_valid <= w_rd;
            r_rd1   <= w_rd ? w_rd1 : '0;
            r_rd2   <= w_rd ? w_rd2 : '0;
        end
    end
endmodule

// File: tb/tb_datamem_mp.sv
// tb_datamem_mp: randomized and directed checks of datamem_mp against a word-level reference model
module tb_datamem_mp;
    localparam int DW = 8, AW = 6, N = 64, IC = 4;
`ifdef DATAMEM_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, clear = 1'b0, write_en = 1'b0, read = 1'b0;
    logic [AW-1:0] write_adr = '0, read_adr1 = '0, read_adr2 = '0;
    logic [DW-1:0] write_data = '0, read_data1, read_data2;
    logic read_valid, busy;
    logic rst2 = 1'b1, clear2 = 1'b0, we2 = 1'b0, rd2 = 1'b0;
    logic [3:0] wa2 = '0, ra21 = '0, ra22 = '0;
    logic [15:0] wd2 = '0, q21, q22;
    logic v2, b2;
    int checks = 0, errors = 0;
    logic [DW-1:0] m_mem [N];
    int m_left = N;
    logic m_valid = 1'b0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;

    always #5 clk = ~clk;

    datamem_mp dut (
        .clk(clk), .rst(rst), .clear(clear), .write_en(write_en), .write_adr(write_adr),
        .write_data(write_data), .read(read), .read_adr1(read_adr1), .read_adr2(read_adr2),
        .read_data1(read_data1), .read_data2(read_data2), .read_valid(read_valid), .busy(busy)
    );

    datamem_mp #(.DATA_W(16), .ADDR_W(4), .INIT_CNT(2)) dut2 (
        .clk(clk), .rst(rst2), .clear(clear2), .write_en(we2), .write_adr(wa2),
        .write_data(wd2), .read(rd2), .read_adr1(ra21), .read_adr2(ra22),
        .read_data1(q21), .read_data2(q22), .read_valid(v2), .busy(b2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rd, input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic clr);
        write_en = we; write_adr = wa; write_data = wd;
        read = rd; read_adr1 = a1; read_adr2 = a2; clear = clr;
    endtask

    task automatic model_edge();
        logic [DW-1:0] o1, o2;
        if (rst) begin
            m_left = N; m_valid = 1'b0; m_d1 = '0; m_d2 = '0;
        end else if (m_left > 0) begin
            m_valid = 1'b0; m_d1 = '0; m_d2 = '0;
            if (clear) m_left = N;
            else begin
                m_left--;
                if (m_left == 0)
                    for (int a = 0; a < N; a++) m_mem[a] = (a < IC) ? DW'(a + 1) : '0;
            end
        end else if (clear) begin
            m_left = N; m_valid = 1'b0; m_d1 = '0; m_d2 = '0;
        end else begin
            o1 = m_mem[read_adr1];
            o2 = m_mem[read_adr2];
            if (write_en) begin
                m_mem[write_adr] = write_data;
                if (BYP) begin
                    o1 = m_mem[read_adr1];
                    o2 = m_mem[read_adr2];
                end
            end
            m_valid = read;
            m_d1 = read ? o1 : '0;
            m_d2 = read ? o2 : '0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_left > 0));
        chk({tag, ".valid"}, 32'(read_valid), 32'(m_valid));
        chk({tag, ".d1"}, 32'(read_data1), 32'(m_d1));
        chk({tag, ".d2"}, 32'(read_data2), 32'(m_d2));
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_drive(input bit allow_clear);
        drive(1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom),
              1'($urandom_range(1)), AW'($urandom_range(15)), AW'($urandom_range(15)),
              allow_clear && ($urandom_range(39) == 0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rand_drive(1'b0);
            tick("sweep");
        end
        chk("sweep_done_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, '0, 1'b1, AW'(i), AW'(4 - i), 1'b0);
            tick("init_rd");
            chk("init_val", 32'(read_data1), (i < IC) ? 32'(i + 1) : 32'd0);
        end
        drive(1'b1, AW'(10), 8'hA5, 1'b0, '0, '0, 1'b0);
        tick("wr10");
        drive(1'b0, '0, '0, 1'b1, AW'(10), AW'(3), 1'b0);
        tick("rd10");
        chk("rd10_d1", 32'(read_data1), 32'hA5);
        chk("rd10_d2", 32'(read_data2), 32'h04);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        tick("rd10_idle");
        chk("valid_one_cycle", 32'(read_valid), 32'd0);
        drive(1'b1, AW'(7), 8'h5A, 1'b1, AW'(7), AW'(7), 1'b0);
        tick("wr_rd_same");
        chk("collide_d1", 32'(read_data1), BYP ? 32'h5A : 32'h00);
        drive(1'b0, '0, '0, 1'b1, AW'(7), AW'(7), 1'b0);
        tick("collide_after");
        chk("collide_after_d1", 32'(read_data1), 32'h5A);
        for (int i = 0; i < 300; i++) begin
            rand_drive(1'b1);
            tick("rand");
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < N + 2 && m_left > 0; i++) tick("settle");
        drive(1'b1, AW'(63), 8'hFF, 1'b0, '0, '0, 1'b0);
        tick("wr63");
        drive(1'b1, AW'(5), 8'h11, 1'b1, AW'(5), AW'(5), 1'b1);
        tick("clear");
        chk("clear_busy", 32'(busy), 32'd1);
        for (int i = 0; i < N; i++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
            tick("clear_sweep");
        end
        chk("clear_sweep_done", 32'(busy), 32'd0);
        drive(1'b0, '0, '0, 1'b1, AW'(63), AW'(5), 1'b0);
        tick("rd_after_clear");
        chk("adr63_cleared", 32'(read_data1), 32'd0);
        chk("adr5_cleared", 32'(read_data2), 32'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
        tick("clear2");
        for (int i = 0; i < 20; i++) begin
            rand_drive(1'b0);
            tick("pre_rst");
        end
        rst = 1'b1;
        m_left = N; m_valid = 1'b0; m_d1 = '0; m_d2 = '0;
        #1;
        check_all("async_rst");
        for (int i = 0; i < 2; i++) begin
            rand_drive(1'b0);
            tick("in_rst");
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            rand_drive(1'b0);
            tick("resweep");
            chk("resweep_busy", 32'(busy), 32'(i < N - 1));
        end
        drive(1'b0, '0, '0, 1'b1, AW'(2), AW'(40), 1'b0);
        tick("post_rst_rd");
        chk("post_rst_d1", 32'(read_data1), 32'd3);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        rst2 = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            chk("p_busy", 32'(b2), 32'(i < 16));
        end
        rd2 = 1'b1; ra21 = 4'd0; ra22 = 4'd1;
        @(posedge clk);
        #1;
        chk("p_rd0", 32'(q21), 32'd1);
        chk("p_rd1", 32'(q22), 32'd2);
        chk("p_valid", 32'(v2), 32'd1);
        ra21 = 4'd2; ra22 = 4'd15;
        @(posedge clk);
        #1;
        chk("p_rd2", 32'(q21), 32'd0);
        rd2 = 1'b0; we2 = 1'b1; wa2 = 4'd15; wd2 = 16'hBEEF;
        @(posedge clk);
        #1;
        chk("p_idle_valid", 32'(v2), 32'd0);
        we2 = 1'b0; rd2 = 1'b1; ra21 = 4'd15; ra22 = 4'd15;
        @(posedge clk);
        #1;
        chk("p_beef1", 32'(q21), 32'hBEEF);
        chk("p_beef2", 32'(q22), 32'hBEEF);
        rd2 = 1'b0;
        @(posedge clk);
        #1;
        chk("p_zero_data", 32'(q21), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
